// File: rtl/divide_sequencer_if.sv
// Request, divider-launch and response signals of the divide sequencer.
// slave is the sequencer's own view; master is the view of the environment around it.
interface divide_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_half;
  logic [0:63] req_dividend;
  logic [0:31] req_divisor;
  logic        div_start;
  logic [0:63] div_numerator;
  logic [0:31] div_denominator;
  logic        div_done;
  logic [0:31] div_quotient;
  logic [0:31] div_remainder;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:31] rsp_quotient;
  logic [0:31] rsp_remainder;
  logic        rsp_overflow;
  logic        rsp_error;

  modport slave (
    input  req_valid, req_half, req_dividend, req_divisor,
    input  div_done, div_quotient, div_remainder, rsp_ready,
    output req_ready, div_start, div_numerator, div_denominator,
    output rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow, rsp_error
  );

  modport master (
    output req_valid, req_half, req_dividend, req_divisor,
    output div_done, div_quotient, div_remainder, rsp_ready,
    input  req_ready, div_start, div_numerator, div_denominator,
    input  rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow, rsp_error
  );
endinterface

// File: rtl/divide_sequencer.sv
// Sequences one signed divide through an external iterative divider: overflow screen, launch, timeouts.
// Overflow answers two cycles after accept; the result is held until rsp_ready, and req_ready is high only when idle.
module divide_sequencer #(
  parameter int ACK_LIMIT  = 4,
  parameter int BUSY_LIMIT = 255
) (
  input logic               clock,
  input logic               reset_n,
  divide_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;

  localparam logic [7:0] ACK_LAST  = 8'(ACK_LIMIT - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_LIMIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        half_q;
  logic [0:63] num_q;
  logic [0:31] den_q;
  logic        ovf_q;
  logic [0:31] quo_q, rem_q;
  logic        ovf_flag_q, err_q;
  logic        accept;

  logic [64:0] num_ext, den_ext, num_mag, den_mag, num_shift;
  logic        ovf_calc;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    num_ext   = {num_q[0], num_q};
    den_ext   = {{33{den_q[0]}}, den_q};
    num_mag   = num_ext[64] ? (~num_ext + 65'd1) : num_ext;
    den_mag   = den_ext[64] ? (~den_ext + 65'd1) : den_ext;
    num_shift = half_q ? (num_mag >> 15) : (num_mag >> 31);
    ovf_calc  = (den_q == '0) || (num_shift >= den_mag);
  end

  // The overflow compare is registered in the first CHECK cycle and acted on in the second.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.req_valid) state_nxt = CHECK;
      CHECK:     if (cnt != '0) begin
                   if (ovf_q)             state_nxt = RESP;
                   else if (bus.div_done) state_nxt = ISSUE;
                 end
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (!bus.div_done)       state_nxt = WAIT_DONE;
                 else if (cnt == ACK_LAST) state_nxt = RESP;
      WAIT_DONE: if (bus.div_done || cnt == BUSY_LAST) state_nxt = RESP;
      RESP:      if (bus.rsp_ready)       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != 8'hFF)  cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q     <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      ovf_q      <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      ovf_flag_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        half_q     <= bus.req_half;
        num_q      <= bus.req_half ? {{32{bus.req_dividend[32]}}, bus.req_dividend[32:63]}
                                   : bus.req_dividend;
        den_q      <= bus.req_half ? {{16{bus.req_divisor[16]}}, bus.req_divisor[16:31]}
                                   : bus.req_divisor;
        quo_q      <= '0;
        rem_q      <= '0;
        ovf_flag_q <= 1'b0;
        err_q      <= 1'b0;
      end
      if (state == CHECK) ovf_q <= ovf_calc;
      if (state == CHECK && cnt != '0 && ovf_q) ovf_flag_q <= 1'b1;
      if (state == WAIT_ACK && bus.div_done && cnt == ACK_LAST) err_q <= 1'b1;
      if (state == WAIT_DONE) begin
        if (bus.div_done) begin
          quo_q <= bus.div_quotient;
          rem_q <= bus.div_remainder;
        end else if (cnt == BUSY_LAST) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready       = (state == IDLE);
  assign bus.div_start       = (state == ISSUE);
  assign bus.div_numerator   = num_q;
  assign bus.div_denominator = den_q;
  assign bus.rsp_valid       = (state == RESP);
  assign bus.rsp_quotient    = quo_q;
  assign bus.rsp_remainder   = rem_q;
  assign bus.rsp_overflow    = ovf_flag_q;
  assign bus.rsp_error       = err_q;

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: directed and random divides against an arithmetic reference,
// with a behavioural stub divider that can also be made to stick high or low.
module tb_divide_sequencer;
  localparam int ACK_LIM  = 4;
  localparam int BUSY_LIM = 255;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  divide_sequencer_if ifc ();

  divide_sequencer #(.ACK_LIMIT(ACK_LIM), .BUSY_LIMIT(BUSY_LIM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;

  // Stub divider: mode 0 divides with a fixed latency, 1 never acknowledges, 2 never finishes.
  int          stub_mode = 0;
  int          stub_lat = 3;
  int          stub_wait = 0;
  bit          stub_busy = 1'b0;
  logic        stub_done = 1'b1;
  logic [31:0] stub_q = '0, stub_r = '0;
  logic        manual_en = 1'b0, manual_done = 1'b0;
  longint      sn, sd;

  assign ifc.div_done      = manual_en ? manual_done : stub_done;
  assign ifc.div_quotient  = stub_q;
  assign ifc.div_remainder = stub_r;

  always @(posedge clock) begin
    if (ifc.div_start === 1'b1) start_cnt <= start_cnt + 1;
    case (stub_mode)
      0: begin
        if (stub_busy) begin
          if (stub_wait == 0) begin stub_done <= 1'b1; stub_busy <= 1'b0; end
          else stub_wait <= stub_wait - 1;
        end else if (ifc.div_start === 1'b1) begin
          sn = longint'($signed(ifc.div_numerator));
          sd = longint'($signed(ifc.div_denominator));
          stub_done <= 1'b0;
          stub_busy <= 1'b1;
          stub_wait <= stub_lat;
          if (sd != 0) begin
            stub_q <= 32'(sn / sd);
            stub_r <= 32'(sn % sd);
          end
        end else begin
          stub_done <= 1'b1;
        end
      end
      1: stub_done <= 1'b1;
      default: if (ifc.div_start === 1'b1) stub_done <= 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: signed truncating divide of the mode-selected operands, with the magnitude overflow screen.
  function automatic void model(input logic half, input logic [0:63] dvd, input logic [0:31] dvs,
                                output logic [31:0] q, output logic [31:0] r, output logic ovf,
                                output logic [63:0] n_ext, output logic [31:0] d_ext);
    logic signed [31:0] h32, w32;
    logic signed [15:0] h16;
    longint n, d, an, ad, lim;
    h32 = dvd[32:63];
    h16 = dvs[16:31];
    w32 = dvs;
    if (half) begin n = longint'(h32); d = longint'(h16); lim = 64'sd32768; end
    else      begin n = longint'(dvd); d = longint'(w32); lim = 64'sd2147483648; end
    an = (n < 0) ? -n : n;
    ad = (d < 0) ? -d : d;
    ovf = (d == 0) || ((an / lim) >= ad);
    q = '0;
    r = '0;
    if (!ovf) begin q = 32'(n / d); r = 32'(n % d); end
    n_ext = 64'(n);
    d_ext = 32'(d);
  endfunction

  task automatic do_op(input string tag, input logic half, input logic [0:63] dvd, input logic [0:31] dvs,
                       input int stall, output logic [31:0] q, output logic [31:0] r,
                       output logic ovf, output logic err, output int lat_start, output int lat_rsp,
                       output int starts, output logic [63:0] num_seen, output logic [31:0] den_seen);
    int c;
    int s0;
    c = 0;
    while (ifc.req_ready !== 1'b1 && c < 50) begin step(); c++; end
    s0 = start_cnt;
    lat_start = -1;
    num_seen = '0;
    den_seen = '0;
    ifc.req_half = half;
    ifc.req_dividend = dvd;
    ifc.req_divisor = dvs;
    ifc.req_valid = 1'b1;
    step();
    ifc.req_valid = 1'b0;
    ifc.req_dividend = {$urandom(), $urandom()};
    ifc.req_divisor = $urandom();
    c = 0;
    while (ifc.rsp_valid !== 1'b1 && c < 400) begin
      step();
      c++;
      if (ifc.div_start === 1'b1 && lat_start < 0) begin
        lat_start = c;
        num_seen = ifc.div_numerator;
        den_seen = ifc.div_denominator;
      end
    end
    chk({tag, ".rsp_seen"}, 64'(ifc.rsp_valid), 64'd1);
    lat_rsp = c;
    q = ifc.rsp_quotient;
    r = ifc.rsp_remainder;
    ovf = ifc.rsp_overflow;
    err = ifc.rsp_error;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".hold_qr"}, {ifc.rsp_quotient, ifc.rsp_remainder}, {q, r});
      chk({tag, ".hold_flags"}, 64'({ifc.rsp_valid, ifc.rsp_overflow, ifc.rsp_error}), 64'({1'b1, ovf, err}));
      chk({tag, ".hold_req_ready"}, 64'(ifc.req_ready), 64'd0);
    end
    ifc.rsp_ready = 1'b1;
    step();
    ifc.rsp_ready = 1'b0;
    chk({tag, ".released"}, 64'({ifc.rsp_valid, ifc.req_ready}), 64'b01);
    starts = start_cnt - s0;
  endtask

  task automatic check_op(input string tag, input logic half, input logic [0:63] dvd, input logic [0:31] dvs,
                          input int stall, input logic exp_err, input int exp_lat);
    logic [31:0] q, r, eq, er, ds, ed;
    logic        ovf, err, eo;
    logic [63:0] ns, en;
    int          ls, lr, st;
    model(half, dvd, dvs, eq, er, eo, en, ed);
    do_op(tag, half, dvd, dvs, stall, q, r, ovf, err, ls, lr, st, ns, ds);
    if (exp_err) begin eq = '0; er = '0; end
    chk({tag, ".quotient"}, 64'(q), 64'(eq));
    chk({tag, ".remainder"}, 64'(r), 64'(er));
    chk({tag, ".flags"}, 64'({ovf, err}), 64'({eo, exp_err}));
    chk({tag, ".starts"}, 64'(st), eo ? 64'd0 : 64'd1);
    if (eo) begin
      chk({tag, ".ovf_latency"}, 64'(lr), 64'd2);
    end else begin
      chk({tag, ".start_latency"}, 64'(ls), 64'd2);
      chk({tag, ".numerator"}, ns, en);
      chk({tag, ".denominator"}, 64'(ds), 64'(ed));
    end
    if (exp_lat > 0) chk({tag, ".rsp_latency"}, 64'(lr), 64'(exp_lat));
  endtask

  initial begin
    logic signed [63:0] t64;
    logic signed [31:0] t32;
    logic [0:63]        rd;
    logic [0:31]        rv;
    logic               rh;
    int                 c, seen, started;

    ifc.req_valid = 1'b0;
    ifc.req_half = 1'b0;
    ifc.req_dividend = '0;
    ifc.req_divisor = '0;
    ifc.rsp_ready = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    chk("reset.ctrl", 64'({ifc.req_ready, ifc.div_start, ifc.rsp_valid, ifc.rsp_overflow, ifc.rsp_error}), 64'b10000);
    chk("reset.rsp_data", {ifc.rsp_quotient, ifc.rsp_remainder}, 64'd0);
    chk("reset.num", 64'(ifc.div_numerator), 64'd0);
    chk("reset.den", 64'(ifc.div_denominator), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    check_op("word", 1'b0, 64'd3550, 32'd113, 0, 1'b0, -1);
    check_op("half", 1'b1, {32'hDEADBEEF, 32'd100}, {16'hABCD, 16'd15}, 0, 1'b0, -1);
    check_op("half_neg", 1'b1, {32'h1234_5678, -32'sd1000}, {16'h5555, -16'sd7}, 1, 1'b0, -1);
    check_op("div_zero", 1'b0, 64'd3550, 32'd0, 0, 1'b0, -1);
    check_op("big", 1'b0, 64'd1 << 40, 32'd1, 0, 1'b0, -1);
    check_op("backpressure", 1'b0, 64'd35500, 32'd112, 5, 1'b0, -1);

    stub_mode = 1;
    check_op("ack_timeout", 1'b0, 64'd3550, 32'd113, 0, 1'b1, 3 + ACK_LIM);
    stub_mode = 2;
    check_op("busy_timeout", 1'b0, 64'd3550, 32'd113, 0, 1'b1, 4 + BUSY_LIM);
    stub_mode = 0;
    step();

    for (int i = 0; i < 12; i++) begin
      rh = 1'($urandom_range(0, 1));
      if (rh) begin
        t32 = $urandom();
        t32 = t32 >>> $urandom_range(0, 18);
        rd = {$urandom(), t32};
        rv = $urandom();
      end else begin
        t64 = {$urandom(), $urandom()};
        t64 = t64 >>> $urandom_range(30, 40);
        rd = t64;
        rv = $urandom();
      end
      stub_lat = $urandom_range(1, 6);
      check_op($sformatf("rand%0d", i), rh, rd, rv, $urandom_range(0, 2), 1'b0, -1);
    end

    // Reset while the divider is busy: the next request must wait for div_done.
    stub_lat = 12;
    ifc.req_half = 1'b0;
    ifc.req_dividend = 64'd3550;
    ifc.req_divisor = 32'd113;
    ifc.req_valid = 1'b1;
    step();
    ifc.req_valid = 1'b0;
    c = 0;
    while (ifc.div_start !== 1'b1 && c < 20) begin step(); c++; end
    chk("rst.start_seen", 64'(ifc.div_start), 64'd1);
    repeat (4) step();
    chk("rst.pending", 64'(ifc.rsp_valid), 64'd0);
    manual_done = 1'b0;
    manual_en = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst.ctrl", 64'({ifc.div_start, ifc.rsp_valid, ifc.rsp_overflow, ifc.rsp_error}), 64'd0);
    chk("rst.rsp_data", {ifc.rsp_quotient, ifc.rsp_remainder}, 64'd0);
    chk("rst.operands", 64'(ifc.div_numerator) | 64'(ifc.div_denominator), 64'd0);
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin step(); if (ifc.rsp_valid === 1'b1) seen++; end
    chk("rst.no_response", 64'(seen), 64'd0);
    ifc.req_dividend = 64'd35500;
    ifc.req_divisor = 32'd112;
    ifc.req_valid = 1'b1;
    step();
    ifc.req_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (ifc.div_start === 1'b1 || ifc.rsp_valid === 1'b1 || ifc.req_ready === 1'b1) seen++;
    end
    chk("rst.stalled", 64'(seen), 64'd0);
    c = 0;
    while (stub_done !== 1'b1 && c < 100) begin step(); c++; end
    manual_en = 1'b0;
    c = 0;
    started = -1;
    while (ifc.rsp_valid !== 1'b1 && c < 50) begin
      step();
      c++;
      if (ifc.div_start === 1'b1 && started < 0) started = c;
    end
    chk("rst.start_after_done", 64'(started), 64'd1);
    chk("rst.result", {ifc.rsp_quotient, ifc.rsp_remainder}, {32'd316, 32'd108});
    chk("rst.flags", 64'({ifc.rsp_valid, ifc.rsp_overflow, ifc.rsp_error}), 64'b100);
    ifc.rsp_ready = 1'b1;
    step();
    ifc.rsp_ready = 1'b0;
    chk("rst.released", 64'(ifc.req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/divide_sequencer.md
DIVIDE_SEQUENCER -- requirements
Module: divide_sequencer

Interface
REQ-001 SHALL have these ports, clock and reset first, all vectors big-endian with bit 0 as MSB:
  clock            in   1   single clock, all state on rising edge
  reset_n          in   1   asynchronous, active-low reset
  req_valid        in   1   divide request present
  req_ready        out  1   sequencer can accept a request
  req_half         in   1   0 = word divide (64/32), 1 = halfword divide (32/16)
  req_dividend     in   64  signed dividend; halfword mode uses bits [32:63] only
  req_divisor      in   32  signed divisor; halfword mode uses bits [16:31] only
  div_start        out  1   one-cycle launch pulse to the downstream iterative divider
  div_numerator    out  64  sign-extended dividend to the divider
  div_denominator  out  32  sign-extended divisor to the divider
  div_done         in   1   divider status: high when idle, low while busy
  div_quotient     in   32  divider quotient
  div_remainder    in   32  divider remainder
  rsp_valid        out  1   result present
  rsp_ready        in   1   consumer accepts the result
  rsp_quotient     out  32  quotient
  rsp_remainder    out  32  remainder
  rsp_overflow     out  1   quotient not representable, or divisor is zero
  rsp_error        out  1   divider handshake timeout
REQ-002 SHALL provide a parameter ACK_LIMIT, default 4: the maximum number of cycles to wait for div_done to fall.
REQ-003 SHALL provide a parameter BUSY_LIMIT, default 255: the maximum number of cycles to wait for div_done to rise.

Function
REQ-004 SHALL implement the states IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE and RESP.
REQ-005 SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-006 SHALL register the operands at acceptance.
  - Word mode: the dividend passes as-is; the divisor passes as-is.
  - Halfword mode: dividend bits [32:63] are sign-extended to 64 bits; divisor bits [16:31] are sign-extended to 32 bits.
REQ-007 SHALL compute overflow in CHECK.
  - Overflow is set when the divisor is 0.
  - Overflow is also set when floor(|N| / 2^k) >= |D|, with k = 31 in word mode and k = 15 in halfword mode.
  - Magnitudes use 65-bit arithmetic.
REQ-008 SHALL, on overflow, go from CHECK to RESP with both results at 0 and rsp_overflow = 1, without asserting div_start.
REQ-009 SHALL stay in CHECK while div_done = 0, so the divider is never started while busy.
REQ-010 SHALL otherwise go CHECK -> ISSUE, and assert div_start for exactly one cycle in ISSUE.
REQ-011 SHALL hold div_numerator and div_denominator stable from ISSUE through WAIT_DONE.
REQ-012 SHALL behave as follows in WAIT_ACK:
  - div_done = 0 -> go to WAIT_DONE.
  - ACK_LIMIT cycles elapse without div_done falling -> go to RESP with rsp_error = 1 and both results at 0.
REQ-013 SHALL behave as follows in WAIT_DONE:
  - div_done = 1 -> capture div_quotient and div_remainder, go to RESP.
  - BUSY_LIMIT cycles elapse first -> go to RESP with rsp_error = 1.
REQ-014 SHALL use a single 8-bit cycle counter, cleared on every state entry, for both timeouts.
REQ-015 SHALL assert rsp_valid only in RESP, and hold all rsp_* outputs stable until rsp_ready is high.
  - rsp_valid and rsp_ready both high at an edge -> return to IDLE.
  - rsp_valid may deassert in the same cycle a new request is accepted.
REQ-016 SHALL give these latencies from the accept edge T:
  - Overflow: rsp_valid high after edge T+2.
  - Normal case: div_start high after edge T+2, when div_done = 1 in CHECK.
REQ-017 SHALL never assert rsp_overflow and rsp_error together.

Reset
REQ-018 SHALL, while reset_n = 0, immediately force the following regardless of clock:
  - state to IDLE;
  - req_ready = 1 once reset_n is high;
  - div_start, rsp_valid, rsp_overflow and rsp_error to 0;
  - all data outputs and the counter to 0.
REQ-019 SHALL discard any in-flight operation on reset and issue no response for it.
  - A divider still busy after reset is handled by REQ-009: the next request waits in CHECK.

Verification
REQ-020 Word divide: N = 3550, D = 113 -> one div_start pulse, then rsp_quotient 31, rsp_remainder 47, no flags.
REQ-021 Halfword divide: dividend bits [32:63] = 100, divisor bits [16:31] = 15 -> div_denominator 15, result quotient 6, remainder 10.
REQ-022 Overflow:
  - D = 0 -> rsp_overflow = 1 two cycles after accept, div_start never asserted.
  - N = 2^40, D = 1 -> rsp_overflow = 1.
REQ-023 Backpressure: N = 35500, D = 112, rsp_ready low for 5 cycles -> quotient 316 and remainder 108 held stable, req_ready low throughout.
REQ-024 Timeouts with a stub divider:
  - div_done stuck high -> rsp_error = 1 after ACK_LIMIT cycles in WAIT_ACK.
  - div_done stuck low after the acknowledge -> rsp_error = 1 after BUSY_LIMIT cycles.
REQ-025 Reset mid-operation: reset_n pulsed low during WAIT_DONE -> all outputs 0, no response emitted; the next request stalls in CHECK until div_done = 1.
